// File: rtl/ats_pkg.sv
// Shared ATS definitions used by the eligibility calculator and the release queue.
package ats_pkg;

    localparam int TIMESTAMP_WIDTH = 59;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } ats_state_e;

    // True when now is at or past t on a wrapping time base (equality counts as reached)
    function automatic logic time_reached(
        input logic [TIMESTAMP_WIDTH-1:0] now,
        input logic [TIMESTAMP_WIDTH-1:0] t
    );
        logic [TIMESTAMP_WIDTH-1:0] diff;
        diff = now - t;
        return ~diff[TIMESTAMP_WIDTH-1];
    endfunction

endpackage

// File: rtl/ats_eligibility_release_queue_if.sv
// Frame handshake between the eligibility calculator, the release queue and
// transmission selection. The queue itself connects through the slave modport.
interface ats_eligibility_release_queue_if #(
    parameter int TIMESTAMP_WIDTH = ats_pkg::TIMESTAMP_WIDTH,
    parameter int DESC_WIDTH      = 32
);
    logic                       in_valid;
    logic                       in_discard;
    logic [TIMESTAMP_WIDTH-1:0] in_eligible_time;
    logic [DESC_WIDTH-1:0]      in_desc;
    logic                       out_valid;
    logic                       out_ready;
    logic [DESC_WIDTH-1:0]      out_desc;
    logic [TIMESTAMP_WIDTH-1:0] out_eligible_time;

    modport master (
        output in_valid, in_discard, in_eligible_time, in_desc, out_ready,
        input  out_valid, out_desc, out_eligible_time
    );

    modport slave (
        input  in_valid, in_discard, in_eligible_time, in_desc, out_ready,
        output out_valid, out_desc, out_eligible_time
    );

endinterface

// File: rtl/ats_desc_fifo.sv
// Synchronous descriptor FIFO with a combinational head read port; DEPTH must be
// a power of two so the pointers wrap naturally.
module ats_desc_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 91
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full      = (count_r == DEPTH_CNT);
    assign do_wr_s   = wr_en & ~full;
    assign do_rd_s   = rd_en & (count_r != {CW{1'b0}});
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array is left unreset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ats_eligibility_release_queue.sv
// ATS eligibility release queue: holds descriptors in strict FIFO order and
// presents the head to transmission selection once local time reaches its eligibility time.
module ats_eligibility_release_queue #(
    parameter int DEPTH           = 16,
    parameter int TIMESTAMP_WIDTH = ats_pkg::TIMESTAMP_WIDTH,
    parameter int DESC_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    ats_eligibility_release_queue_if.slave bus,
    input  logic [TIMESTAMP_WIDTH-1:0]    current_time,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          full,
    output logic [15:0]                   discard_count,
    output logic [15:0]                   overflow_count
);
    import ats_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = TIMESTAMP_WIDTH + DESC_WIDTH;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    ats_state_e                 state_r;
    ats_state_e                 state_nxt_s;
    logic [EW-1:0]              head_s;
    logic [TIMESTAMP_WIDTH-1:0] head_time_s;
    logic [DESC_WIDTH-1:0]      head_desc_s;
    logic [CW-1:0]              count_s;
    logic                       full_s;
    logic                       wr_s;
    logic                       pop_s;
    logic                       elig_s;
    logic                       load_s;
    logic                       disc_s;
    logic                       ovf_s;
    logic                       out_valid_r;
    logic [DESC_WIDTH-1:0]      out_desc_r;
    logic [TIMESTAMP_WIDTH-1:0] out_time_r;
    logic [15:0]                discard_count_r;
    logic [15:0]                overflow_count_r;

    // full is the start-of-cycle value, so a same-cycle pop never frees room for a write
    assign wr_s        = bus.in_valid & ~bus.in_discard & ~full_s;
    assign disc_s      = bus.in_valid & bus.in_discard;
    assign ovf_s       = bus.in_valid & ~bus.in_discard & full_s;
    assign pop_s       = out_valid_r & bus.out_ready;
    assign head_time_s = head_s[EW-1 -: TIMESTAMP_WIDTH];
    assign head_desc_s = head_s[DESC_WIDTH-1:0];
    assign elig_s      = time_reached(current_time, head_time_s);
    assign load_s      = (state_r == ST_WAIT) & elig_s;

    ats_desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_s),
        .wr_data   ({bus.in_eligible_time, bus.in_desc}),
        .rd_en     (pop_s),
        .head_data (head_s),
        .count     (count_s),
        .full      (full_s)
    );

    // Next-state: the head is only ever compared while waiting, so no entry overtakes it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (wr_s) state_nxt_s = ST_WAIT;
                else      state_nxt_s = ST_EMPTY;
            end
            ST_WAIT: begin
                if (elig_s) state_nxt_s = ST_PRESENT;
                else        state_nxt_s = ST_WAIT;
            end
            ST_PRESENT: begin
                if (pop_s && (count_s == CNT_ONE) && !wr_s) state_nxt_s = ST_EMPTY;
                else if (pop_s)                             state_nxt_s = ST_WAIT;
                else                                        state_nxt_s = ST_PRESENT;
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State, presented head snapshot and saturating drop counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_EMPTY;
            out_valid_r      <= 1'b0;
            out_desc_r       <= '0;
            out_time_r       <= '0;
            discard_count_r  <= 16'd0;
            overflow_count_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_PRESENT);
            if (load_s) begin
                out_desc_r <= head_desc_s;
                out_time_r <= head_time_s;
            end
            if (disc_s && (discard_count_r != 16'hFFFF)) begin
                discard_count_r <= discard_count_r + 16'd1;
            end
            if (ovf_s && (overflow_count_r != 16'hFFFF)) begin
                overflow_count_r <= overflow_count_r + 16'd1;
            end
        end
    end

    assign bus.out_valid         = out_valid_r;
    assign bus.out_desc          = out_desc_r;
    assign bus.out_eligible_time = out_time_r;
    assign fifo_count            = count_s;
    assign full                  = full_s;
    assign discard_count         = discard_count_r;
    assign overflow_count        = overflow_count_r;

endmodule

// File: tb/tb_ats_eligibility_release_queue.sv
// Bench for the ATS release queue: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_ats_eligibility_release_queue;
    localparam int DEPTH = 4;
    localparam int TSW   = 59;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [TSW-1:0] HALF  = 59'd1 << 58;
    localparam logic [TSW-1:0] T_MAX = '1;

    typedef struct {
        logic [TSW-1:0] t;
        logic [DW-1:0]  d;
    } ent_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [TSW-1:0] current_time = '0;
    logic [CW-1:0]  fifo_count;
    logic           full;
    logic [15:0]    discard_count;
    logic [15:0]    overflow_count;

    ats_eligibility_release_queue_if #(.TIMESTAMP_WIDTH(TSW), .DESC_WIDTH(DW)) bus ();

    ats_eligibility_release_queue #(
        .DEPTH(DEPTH), .TIMESTAMP_WIDTH(TSW), .DESC_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .current_time   (current_time),
        .fifo_count     (fifo_count),
        .full           (full),
        .discard_count  (discard_count),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    // Reference model state: what the DUT should show after the most recent clock edge
    ent_t           mq[$];
    bit             m_valid;
    logic [TSW-1:0] m_time;
    logic [DW-1:0]  m_desc;
    logic [15:0]    m_disc;
    logic [15:0]    m_ovf;
    logic [TSW-1:0] now_v;
    int             n_checks = 0;
    int             n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_reached(input logic [TSW-1:0] now, input logic [TSW-1:0] t);
        logic [TSW-1:0] d;
        d = now - t;
        return d < HALF;
    endfunction

    task automatic compare_all();
        check_eq("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check_eq("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check_eq("full", 64'(full), 64'(mq.size() == DEPTH));
        check_eq("discard_count", 64'(discard_count), 64'(m_disc));
        check_eq("overflow_count", 64'(overflow_count), 64'(m_ovf));
        if (m_valid) begin
            check_eq("out_desc", 64'(bus.out_desc), 64'(m_desc));
            check_eq("out_eligible_time", 64'(bus.out_eligible_time), 64'(m_time));
        end
    endtask

    // One clock: check outputs, drive this cycle's inputs and advance the model
    task automatic cycle(input bit v, input bit disc, input logic [TSW-1:0] t, input bit rdy);
        ent_t e;
        bit   pop;
        bit   fl;
        bit   wr;
        @(negedge clk);
        compare_all();
        e.t = t;
        e.d = $urandom();
        bus.in_valid         = v;
        bus.in_discard       = disc;
        bus.in_eligible_time = t;
        bus.in_desc          = e.d;
        bus.out_ready        = rdy;
        current_time         = now_v;
        pop = m_valid && rdy;
        fl  = (mq.size() == DEPTH);
        wr  = v && !disc && !fl;
        if (v && disc && m_disc != 16'hFFFF) m_disc++;
        if (v && !disc && fl && m_ovf != 16'hFFFF) m_ovf++;
        if (m_valid) begin
            if (pop) begin
                m_valid = 1'b0;
                void'(mq.pop_front());
            end
        end else if (mq.size() > 0 && m_reached(now_v, mq[0].t)) begin
            m_valid = 1'b1;
            m_time  = mq[0].t;
            m_desc  = mq[0].d;
        end
        if (wr) mq.push_back(e);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, rdy);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_out_desc"}, 64'(bus.out_desc), 64'd0);
        check_eq({tag, "_out_time"}, 64'(bus.out_eligible_time), 64'd0);
        check_eq({tag, "_fifo_count"}, 64'(fifo_count), 64'd0);
        check_eq({tag, "_full"}, 64'(full), 64'd0);
        check_eq({tag, "_discard"}, 64'(discard_count), 64'd0);
        check_eq({tag, "_overflow"}, 64'(overflow_count), 64'd0);
    endtask

    task automatic drive_idle_inputs();
        bus.in_valid         = 1'b0;
        bus.in_discard       = 1'b0;
        bus.in_eligible_time = '0;
        bus.in_desc          = '0;
        bus.out_ready        = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        compare_all();
        drive_idle_inputs();
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        mq.delete();
        m_valid = 1'b0;
        m_disc  = 16'd0;
        m_ovf   = 16'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic scen_basic();
        now_v = 59'd500;
        cycle(1'b1, 1'b0, 59'd1000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            now_v = now_v + 59'd100;
            idle(1, 1'b1);
        end
        idle(1, 1'b1);
        check_eq("basic_drained", 64'(fifo_count), 64'd0);
    endtask

    initial begin
        drive_idle_inputs();
        m_valid = 1'b0;
        m_time  = '0;
        m_desc  = '0;
        m_disc  = 16'd0;
        m_ovf   = 16'd0;
        now_v   = '0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;

        scen_basic();

        // head-of-line: the later, earlier-timed entry must wait behind the head
        now_v = 59'd1000;
        cycle(1'b1, 1'b0, 59'd5000, 1'b1);
        cycle(1'b1, 1'b0, 59'd2000, 1'b1);
        now_v = 59'd3000;
        idle(6, 1'b1);
        check_eq("hol_blocked", 64'(bus.out_valid), 64'd0);
        now_v = 59'd5000;
        idle(8, 1'b1);

        // backpressure on an eligible head
        now_v = 59'd8000;
        cycle(1'b1, 1'b0, 59'd7000, 1'b0);
        idle(12, 1'b0);
        check_eq("bp_held_valid", 64'(bus.out_valid), 64'd1);
        idle(1, 1'b1);
        idle(3, 1'b1);

        // fill to DEPTH, overflow, then write+pop while full
        now_v = 59'd100000;
        cycle(1'b1, 1'b0, now_v, 1'b0);
        cycle(1'b1, 1'b0, now_v, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, now_v + 59'd1000000, 1'b0);
        idle(2, 1'b0);
        check_eq("full_flag", 64'(full), 64'd1);
        check_eq("overflow_one", 64'(overflow_count), 64'd1);
        cycle(1'b1, 1'b0, now_v, 1'b1);
        idle(1, 1'b0);
        check_eq("overflow_two", 64'(overflow_count), 64'd2);
        check_eq("count_after_pop", 64'(fifo_count), 64'd3);
        idle(3, 1'b0);
        check_eq("present_before_reset", 64'(bus.out_valid), 64'd1);

        mid_reset();
        scen_basic();

        // discard, then eligibility across the time wrap
        cycle(1'b1, 1'b1, 59'd123, 1'b1);
        idle(1, 1'b1);
        check_eq("discard_one", 64'(discard_count), 64'd1);
        check_eq("discard_no_store", 64'(fifo_count), 64'd0);
        now_v = T_MAX - 59'd19;
        cycle(1'b1, 1'b0, T_MAX - 59'd9, 1'b1);
        cycle(1'b1, 1'b0, 59'd5, 1'b1);
        for (int i = 0; i < 14; i++) begin
            now_v = now_v + 59'd5;
            idle(1, 1'b1);
        end
        check_eq("wrap_drained", 64'(fifo_count), 64'd0);

        // random traffic, starting close enough to the wrap to cross it
        now_v = T_MAX - 59'd30000;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit dsc;
            bit rdy;
            logic [TSW-1:0] t;
            v   = ($urandom_range(0, 2) == 0);
            dsc = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            t   = now_v + 59'($urandom_range(0, 400)) - 59'd100;
            cycle(v, dsc, t, rdy);
            now_v = now_v + 59'($urandom_range(0, 40));
        end
        idle(40, 1'b1);
        @(negedge clk);
        compare_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
